// File: rtl/counter_seq_checker.sv
// Receive-side monitor for two wrap-around counter streams: per-channel lock FSM,
// sequence/range/skew error pulses, saturating error counts and a sticky error flag.
module counter_seq_checker #(
  parameter int unsigned LIMIT      = 10,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [3:0]       counter1,
  input  logic [3:0]       counter2,
  input  logic             clear,
  output logic             locked1,
  output logic             locked2,
  output logic             seq_err1,
  output logic             seq_err2,
  output logic             skew_err,
  output logic [ERR_W-1:0] err1_cnt,
  output logic [ERR_W-1:0] err2_cnt,
  output logic             any_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [3:0]       LIM4    = 4'(LIMIT);
  localparam logic [3:0]       LOCK4   = 4'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  logic [1:0] state1_q, state1_d, state2_q, state2_d;
  logic [3:0] prev1_q, prev1_d, prev2_q, prev2_d;
  logic [3:0] good1_q, good1_d, good2_q, good2_d;
  logic       err1_d, err2_d, skew_d;
  logic       match1, match2;
  logic [1:0] st1_n, st2_n;
  logic [3:0] prev1_n, prev2_n, good1_n, good2_n;
  logic       err1_n, err2_n;

  // One channel's next state for a sampled value; match is against the expected successor.
  function automatic void ch_next(
    input  logic [1:0] st,
    input  logic [3:0] prev,
    input  logic [3:0] good,
    input  logic [3:0] v,
    output logic [1:0] st_n,
    output logic [3:0] prev_n,
    output logic [3:0] good_n,
    output logic       err,
    output logic       match
  );
    logic [3:0] exp_v;
    logic       oor;
    exp_v  = (prev == LIM4) ? 4'd0 : prev + 4'd1;
    oor    = (v > LIM4);
    match  = (v == exp_v);
    st_n   = st;
    prev_n = prev;
    good_n = good;
    err    = 1'b0;
    case (st)
      ST_IDLE: begin
        if (!oor) begin
          prev_n = v;
          good_n = 4'd0;
          st_n   = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (oor) begin
          st_n = ST_IDLE;
        end else if (match) begin
          prev_n = v;
          good_n = good + 4'd1;
          if (4'(good + 4'd1) == LOCK4) st_n = ST_LOCKED;
        end else begin
          prev_n = v;
          good_n = 4'd0;
        end
      end
      ST_LOCKED: begin
        if (oor) begin
          err  = 1'b1;
          st_n = ST_IDLE;
        end else if (!match) begin
          err    = 1'b1;
          prev_n = v;
          good_n = 4'd0;
          st_n   = ST_SYNC;
        end else begin
          prev_n = v;
        end
      end
      default: st_n = ST_IDLE;
    endcase
  endfunction

  // Next-state and error decode for both channels
  always_comb begin
    state1_d = state1_q;
    state2_d = state2_q;
    prev1_d  = prev1_q;
    prev2_d  = prev2_q;
    good1_d  = good1_q;
    good2_d  = good2_q;
    err1_d   = 1'b0;
    err2_d   = 1'b0;
    skew_d   = 1'b0;
    ch_next(state1_q, prev1_q, good1_q, counter1, st1_n, prev1_n, good1_n, err1_n, match1);
    ch_next(state2_q, prev2_q, good2_q, counter2, st2_n, prev2_n, good2_n, err2_n, match2);
    if (sample_en) begin
      state1_d = st1_n;
      state2_d = st2_n;
      prev1_d  = prev1_n;
      prev2_d  = prev2_n;
      good1_d  = good1_n;
      good2_d  = good2_n;
      err1_d   = err1_n;
      err2_d   = err2_n;
      skew_d   = (state1_q == ST_LOCKED) && (state2_q == ST_LOCKED) &&
                 match1 && match2 && (counter1 != counter2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state1_q <= ST_IDLE;
      state2_q <= ST_IDLE;
      prev1_q  <= 4'd0;
      prev2_q  <= 4'd0;
      good1_q  <= 4'd0;
      good2_q  <= 4'd0;
    end else begin
      state1_q <= state1_d;
      state2_q <= state2_d;
      prev1_q  <= prev1_d;
      prev2_q  <= prev2_d;
      good1_q  <= good1_d;
      good2_q  <= good2_d;
    end
  end

  // Registered status; clear wins over increment and sticky set but not over pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked1  <= 1'b0;
      locked2  <= 1'b0;
      seq_err1 <= 1'b0;
      seq_err2 <= 1'b0;
      skew_err <= 1'b0;
      err1_cnt <= '0;
      err2_cnt <= '0;
      any_err  <= 1'b0;
    end else begin
      locked1  <= (state1_d == ST_LOCKED);
      locked2  <= (state2_d == ST_LOCKED);
      seq_err1 <= err1_d;
      seq_err2 <= err2_d;
      skew_err <= skew_d;
      if (clear) begin
        err1_cnt <= '0;
        err2_cnt <= '0;
        any_err  <= 1'b0;
      end else begin
        if (err1_d && (err1_cnt != CNT_MAX)) err1_cnt <= err1_cnt + ERR_W'(1);
        if (err2_d && (err2_cnt != CNT_MAX)) err2_cnt <= err2_cnt + ERR_W'(1);
        if (err1_d || err2_d || skew_d) any_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker: behavioural model feeds a scoreboard queue,
// plus explicit checks of the lock, error, skew, clear, saturation and reset scenarios.
module tb_counter_seq_checker;

  localparam int unsigned LIMIT      = 10;
  localparam int unsigned LOCK_COUNT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] counter1 = 4'd0;
  logic [3:0] counter2 = 4'd0;

  logic       locked1, locked2, seq_err1, seq_err2, skew_err, any_err;
  logic [7:0] err1_cnt, err2_cnt;
  logic       b_locked1, b_locked2, b_seq_err1, b_seq_err2, b_skew_err, b_any_err;
  logic [1:0] b_err1_cnt, b_err2_cnt;

  counter_seq_checker #(.LIMIT(LIMIT), .LOCK_COUNT(LOCK_COUNT), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .counter1(counter1), .counter2(counter2),
    .clear(clear), .locked1(locked1), .locked2(locked2), .seq_err1(seq_err1), .seq_err2(seq_err2),
    .skew_err(skew_err), .err1_cnt(err1_cnt), .err2_cnt(err2_cnt), .any_err(any_err)
  );

  counter_seq_checker #(.LIMIT(LIMIT), .LOCK_COUNT(LOCK_COUNT), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .counter1(counter1), .counter2(counter2),
    .clear(clear), .locked1(b_locked1), .locked2(b_locked2), .seq_err1(b_seq_err1),
    .seq_err2(b_seq_err2), .skew_err(b_skew_err), .err1_cnt(b_err1_cnt), .err2_cnt(b_err2_cnt),
    .any_err(b_any_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       l1, l2, s1, s2, sk, any;
    logic [7:0] c1a, c2a;
    logic [1:0] c1b, c2b;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural reference: 0 idle, 1 sync, 2 locked
  int m_st[2], m_prev[2], m_good[2], m_ca[2], m_cb[2];
  logic m_any;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_prev[i] = 0; m_good[i] = 0; m_ca[i] = 0; m_cb[i] = 0;
    end
    m_any = 1'b0;
  endtask

  task automatic model_step(input int v1, input int v2, input logic en, input logic clr,
                            output exp_t e);
    int   v[2];
    logic err[2];
    logic mt[2];
    logic both_lk, skew;
    int   nx;
    v[0] = v1; v[1] = v2;
    both_lk = (m_st[0] == 2) && (m_st[1] == 2);
    skew = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nx = (m_prev[i] == LIMIT) ? 0 : m_prev[i] + 1;
      mt[i] = (v[i] == nx);
      err[i] = 1'b0;
      if (en) begin
        if (m_st[i] == 0) begin
          if (v[i] <= LIMIT) begin m_prev[i] = v[i]; m_good[i] = 0; m_st[i] = 1; end
        end else if (m_st[i] == 1) begin
          if (v[i] > LIMIT) m_st[i] = 0;
          else if (mt[i]) begin
            m_prev[i] = v[i]; m_good[i]++;
            if (m_good[i] == LOCK_COUNT) m_st[i] = 2;
          end else begin m_prev[i] = v[i]; m_good[i] = 0; end
        end else begin
          if (v[i] > LIMIT) begin err[i] = 1'b1; m_st[i] = 0; end
          else if (!mt[i]) begin err[i] = 1'b1; m_prev[i] = v[i]; m_good[i] = 0; m_st[i] = 1; end
          else m_prev[i] = v[i];
        end
      end
    end
    if (en) skew = both_lk && mt[0] && mt[1] && (v1 != v2);
    for (int i = 0; i < 2; i++) begin
      if (clr) begin m_ca[i] = 0; m_cb[i] = 0; end
      else if (err[i]) begin
        if (m_ca[i] < 255) m_ca[i]++;
        if (m_cb[i] < 3) m_cb[i]++;
      end
    end
    if (clr) m_any = 1'b0;
    else if (err[0] || err[1] || skew) m_any = 1'b1;
    e.l1 = (m_st[0] == 2); e.l2 = (m_st[1] == 2);
    e.s1 = err[0]; e.s2 = err[1]; e.sk = skew; e.any = m_any;
    e.c1a = 8'(m_ca[0]); e.c2a = 8'(m_ca[1]);
    e.c1b = 2'(m_cb[0]); e.c2b = 2'(m_cb[1]);
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge
  task automatic step(input int v1, input int v2, input logic en = 1'b1, input logic clr = 1'b0);
    exp_t e, got;
    counter1 = 4'(v1); counter2 = 4'(v2); sample_en = en; clear = clr;
    model_step(v1, v2, en, clr, e);
    sb.push_back(e);
    @(posedge clk); #1;
    got = sb.pop_front();
    chk("locked1", 32'(locked1), 32'(got.l1));
    chk("locked2", 32'(locked2), 32'(got.l2));
    chk("seq_err1", 32'(seq_err1), 32'(got.s1));
    chk("seq_err2", 32'(seq_err2), 32'(got.s2));
    chk("skew_err", 32'(skew_err), 32'(got.sk));
    chk("any_err", 32'(any_err), 32'(got.any));
    chk("err1_cnt", 32'(err1_cnt), 32'(got.c1a));
    chk("err2_cnt", 32'(err2_cnt), 32'(got.c2a));
    chk("sat_err1_cnt", 32'(b_err1_cnt), 32'(got.c1b));
    chk("sat_err2_cnt", 32'(b_err2_cnt), 32'(got.c2b));
    clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {locked1, locked2, seq_err1, seq_err2, skew_err, any_err}, 32'd0);
    chk({tag, "_cnts"}, {err1_cnt, err2_cnt}, 32'd0);
    chk({tag, "_sat"}, {b_locked1, b_locked2, b_seq_err1, b_seq_err2, b_skew_err, b_any_err,
                       b_err1_cnt, b_err2_cnt}, 32'd0);
  endtask

  int a, c2v;
  logic [1:0] sat_exp[5];

  initial begin
    model_reset();
    @(posedge clk); #1;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Lock and wrap on channel 1; channel 2 held out of range
    step(0, 15);
    step(1, 15); chk("lock_after_1", 32'(locked1), 32'd0);
    step(2, 15); chk("lock_after_2", 32'(locked1), 32'd1);
    step(9, 3, 1'b0); step(4, 14, 1'b0);
    chk("hold_no_err", 32'(seq_err1), 32'd0);
    for (int k = 3; k <= 12; k++) step(k % 11, 15);
    chk("wrap_err1_cnt", 32'(err1_cnt), 32'd0);

    // Sequence error at 3 -> 5, relock with 6,7
    step(2, 15); step(3, 15);
    step(5, 15);
    chk("seqerr_pulse", 32'(seq_err1), 32'd1);
    chk("seqerr_cnt", 32'(err1_cnt), 32'd1);
    chk("seqerr_unlock", 32'(locked1), 32'd0);
    chk("seqerr_any", 32'(any_err), 32'd1);
    step(6, 15); chk("seqerr_pulse_end", 32'(seq_err1), 32'd0);
    step(7, 15); chk("relock_after_7", 32'(locked1), 32'd1);

    // Out-of-range on channel 2 locked at 9
    step(8, 7); step(9, 8); step(10, 9);
    chk("ch2_locked", 32'(locked2), 32'd1);
    step(0, 12);
    chk("oor_pulse", 32'(seq_err2), 32'd1);
    chk("oor_cnt", 32'(err2_cnt), 32'd1);
    chk("oor_unlock", 32'(locked2), 32'd0);
    step(1, 0); chk("oor_reseed_err", 32'(seq_err2), 32'd0);
    chk("oor_reseed_lock", 32'(locked2), 32'd0);
    step(2, 1); chk("oor_lock_after_1", 32'(locked2), 32'd0);
    step(3, 2); chk("oor_lock_after_2", 32'(locked2), 32'd1);

    // Fresh start for skew: counter2 = counter1 + 1 mod 11
    @(negedge clk); rst_n = 1'b0; model_reset();
    #1 chk_all_zero("mid_reset");
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      step(k % 11, (k + 1) % 11);
      if (k >= 3) chk("skew_pulse", 32'(skew_err), 32'd1);
    end
    chk("skew_cnts", {err1_cnt, err2_cnt}, 32'd0);
    chk("skew_any", 32'(any_err), 32'd1);

    // Clear coincident with a seq_err1
    step(5, 2, 1'b1, 1'b1);
    chk("clear_pulse", 32'(seq_err1), 32'd1);
    chk("clear_cnt", 32'(err1_cnt), 32'd0);
    chk("clear_any", 32'(any_err), 32'd0);

    // Saturation on the 2-bit instance: five relock/error rounds
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    a = 6; c2v = 3;
    for (int r = 0; r < 5; r++) begin
      step(a, c2v); c2v = (c2v + 1) % 11;
      step((a + 1) % 11, c2v); c2v = (c2v + 1) % 11;
      step((a + 3) % 11, c2v); c2v = (c2v + 1) % 11;
      chk("sat_seq", 32'(b_err1_cnt), 32'(sat_exp[r]));
      chk("wide_seq", 32'(err1_cnt), 32'(r + 1));
      a = (a + 4) % 11;
    end

    // Async reset mid-run with both channels locked and nonzero counts
    step(4, c2v); c2v = (c2v + 1) % 11;
    step(5, c2v);
    chk("pre_reset_locked", {30'd0, locked1, locked2}, 32'd3);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    #3 rst_n = 1'b1;
    step(7, 7); chk("post_reset_seed", 32'(locked1), 32'd0);
    step(8, 8); chk("post_reset_sync", 32'(locked1), 32'd0);
    step(9, 9); chk("post_reset_lock", {30'd0, locked1, locked2}, 32'd3);
    step(10, 10); chk("post_reset_noskew", 32'(skew_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
